led_ring_checker: RTL and testbench

- Receive-side checker for the 12-LED rotating ring pattern.
- Samples a 12-bit LED bus, filters glitches and decodes which rotation of the base sequence is shown.
- Checks that successive patterns advance by exactly one step, and reports phase, lock, revolutions and errors.
- Used on the board-test path: the LED drive bus loops back into this block for self-check.

---
 rtl/led_ring_checker_if.sv | 24 ++
 rtl/led_ring_checker.sv | 174 +++++++++++++++++
 tb/tb_led_ring_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/led_ring_checker_if.sv
// LED ring checker bus: observed LED pattern in, decoded status out.
interface led_ring_checker_if;
  logic [11:0] pat_in;
  logic [3:0]  phase;
  logic        phase_valid;
  logic        locked;
  logic        step_pulse;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic [7:0]  rev_count;

  modport master (
    output pat_in,
    input  phase, phase_valid, locked, step_pulse,
    input  err_pulse, err_code, err_count, rev_count
  );

  modport slave (
    input  pat_in,
    output phase, phase_valid, locked, step_pulse,
    output err_pulse, err_code, err_count, rev_count
  );
endinterface

// File: rtl/led_ring_checker.sv
// Loopback checker for a 12-LED rotating ring: sync, debounce,
// decode rotation index and verify single-step advance.
module led_ring_checker #(
  parameter logic [11:0] BASE_PATTERN  = 12'b000011101101,
  parameter int          STABLE_CYCLES = 4,
  parameter logic [27:0] STALL_LIMIT   = 28'd33554432
) (
  input  logic             clk,
  input  logic             rst_n,
  led_ring_checker_if.slave bus
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);

  state_t      state, state_n;
  logic [11:0] sync1, sync2;
  logic [11:0] cand, cand_n;
  logic [11:0] acc, acc_n;
  logic [3:0]  cnt, cnt_n;
  logic [11:0] new_val;
  logic        fire;
  logic [3:0]  idx;
  logic        valid;
  logic [27:0] stall, stall_n;

  logic [3:0]  phase, phase_n;
  logic        pv, pv_n;
  logic        lk, lk_n;
  logic        stp, stp_n;
  logic        err, err_n;
  logic [1:0]  code, code_n;
  logic [7:0]  errs, errs_n;
  logic [7:0]  revs, revs_n;
  logic [3:0]  phase_inc;

  // Accept is resolved on the same edge the counter reaches
  // STABLE_CYCLES, so decode looks at the value being accepted.
  always_comb begin
    cand_n  = cand;
    cnt_n   = cnt;
    acc_n   = acc;
    new_val = cand;
    fire    = 1'b0;
    if (sync2 != cand) begin
      cand_n  = sync2;
      cnt_n   = 4'd1;
      new_val = sync2;
      if (STB == 4'd1) begin
        acc_n = sync2;
        fire  = (sync2 != acc);
      end
    end else if (cnt < STB) begin
      cnt_n = cnt + 4'd1;
      if (cnt_n == STB) begin
        acc_n = cand;
        fire  = (cand != acc);
      end
    end
  end

  always_comb begin
    logic [23:0] dbl;
    idx   = 4'd0;
    valid = 1'b0;
    for (int k = 11; k >= 0; k--) begin
      dbl = {BASE_PATTERN, BASE_PATTERN} << k;
      if (dbl[23:12] == new_val) begin
        idx   = 4'(k);
        valid = 1'b1;
      end
    end
  end

  assign phase_inc = (phase == 4'd11) ? 4'd0 : phase + 4'd1;

  always_comb begin
    state_n = state;
    phase_n = phase;
    pv_n    = pv;
    lk_n    = lk;
    stp_n   = 1'b0;
    err_n   = 1'b0;
    code_n  = code;
    revs_n  = revs;
    stall_n = 28'd0;
    unique case (state)
      SEARCH: begin
        if (fire && valid) begin
          phase_n = idx;
          pv_n    = 1'b1;
          lk_n    = 1'b1;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (fire) begin
          if (!valid) begin
            err_n   = 1'b1;
            code_n  = 2'd2;
            pv_n    = 1'b0;
            lk_n    = 1'b0;
            state_n = SEARCH;
          end else if (idx == phase_inc) begin
            stp_n   = 1'b1;
            phase_n = idx;
            if (idx == 4'd0) revs_n = revs + 8'd1;
          end else begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            phase_n = idx;
          end
        end else if (stall == STALL_LIMIT - 28'd1) begin
          err_n   = 1'b1;
          code_n  = 2'd3;
          pv_n    = 1'b0;
          lk_n    = 1'b0;
          state_n = SEARCH;
        end else begin
          stall_n = stall + 28'd1;
        end
      end
      default: state_n = SEARCH;
    endcase
    errs_n = (err_n && errs != 8'hFF) ? errs + 8'd1 : errs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEARCH;
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      acc   <= '0;
      cnt   <= '0;
      stall <= '0;
      phase <= '0;
      pv    <= 1'b0;
      lk    <= 1'b0;
      stp   <= 1'b0;
      err   <= 1'b0;
      code  <= '0;
      errs  <= '0;
      revs  <= '0;
    end else begin
      state <= state_n;
      sync1 <= bus.pat_in;
      sync2 <= sync1;
      cand  <= cand_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      stall <= stall_n;
      phase <= phase_n;
      pv    <= pv_n;
      lk    <= lk_n;
      stp   <= stp_n;
      err   <= err_n;
      code  <= code_n;
      errs  <= errs_n;
      revs  <= revs_n;
    end
  end

  assign bus.phase       = phase;
  assign bus.phase_valid = pv;
  assign bus.locked      = lk;
  assign bus.step_pulse  = stp;
  assign bus.err_pulse   = err;
  assign bus.err_code    = code;
  assign bus.err_count   = errs;
  assign bus.rev_count   = revs;

endmodule

// File: tb/tb_led_ring_checker.sv
// Directed bench for led_ring_checker with a short stall limit.
module tb_led_ring_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   steps = 0;
  int   errs = 0;
  int   s0, e0;

  led_ring_checker_if bus();

  led_ring_checker #(
    .STALL_LIMIT(28'd20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.step_pulse) steps++;
    if (bus.err_pulse) errs++;
  end

  logic [11:0] p [0:11];
  logic [11:0] inv = 12'b000111111111;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    p[0]  = 12'b000011101101;
    p[1]  = 12'b000111011010;
    p[2]  = 12'b001110110100;
    p[3]  = 12'b011101101000;
    p[4]  = 12'b111011010000;
    p[5]  = 12'b110110100001;
    p[6]  = 12'b101101000011;
    p[7]  = 12'b011010000111;
    p[8]  = 12'b110100001110;
    p[9]  = 12'b101000011101;
    p[10] = 12'b010000111011;
    p[11] = 12'b100001110110;

    bus.pat_in = 12'h000;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_pv", 32'(bus.phase_valid), 0);
    chk("rst_errcnt", 32'(bus.err_count), 0);
    chk("rst_phase", 32'(bus.phase), 0);
    tick(30);
    chk("idle_locked", 32'(bus.locked), 0);
    chk("idle_errcnt", 32'(bus.err_count), 0);

    // lock latency: first sample edge E0, locked after E5
    bus.pat_in = p[0];
    tick(5);
    chk("lat_e4_locked", 32'(bus.locked), 0);
    tick(1);
    chk("lat_e5_locked", 32'(bus.locked), 1);
    chk("lat_e5_phase", 32'(bus.phase), 0);
    chk("lat_e5_pv", 32'(bus.phase_valid), 1);
    chk("lock_no_step", 32'(steps), 0);

    for (int k = 1; k <= 12; k++) begin
      bus.pat_in = p[k % 12];
      tick(8);
    end
    chk("rev_steps", 32'(steps), 12);
    chk("rev_count1", 32'(bus.rev_count), 1);
    chk("rev_errcnt", 32'(bus.err_count), 0);
    chk("rev_phase", 32'(bus.phase), 0);

    for (int k = 1; k <= 3; k++) begin
      bus.pat_in = p[k];
      tick(8);
    end
    chk("at3_phase", 32'(bus.phase), 3);
    bus.pat_in = p[5];
    tick(8);
    chk("skip_code", 32'(bus.err_code), 1);
    chk("skip_phase", 32'(bus.phase), 5);
    chk("skip_locked", 32'(bus.locked), 1);
    chk("skip_errs", 32'(errs), 1);
    s0 = steps;
    bus.pat_in = p[6];
    tick(8);
    chk("after_skip_step", 32'(steps - s0), 1);
    chk("after_skip_phase", 32'(bus.phase), 6);

    bus.pat_in = inv;
    tick(8);
    chk("inv_code", 32'(bus.err_code), 2);
    chk("inv_locked", 32'(bus.locked), 0);
    chk("inv_pv", 32'(bus.phase_valid), 0);
    chk("inv_errcnt", 32'(bus.err_count), 2);
    s0 = steps;
    bus.pat_in = p[7];
    tick(8);
    chk("relock_locked", 32'(bus.locked), 1);
    chk("relock_phase", 32'(bus.phase), 7);
    chk("relock_nostep", 32'(steps - s0), 0);

    for (int k = 8; k <= 14; k++) begin
      bus.pat_in = p[k % 12];
      tick(8);
    end
    chk("at2_phase", 32'(bus.phase), 2);
    chk("rev_count2", 32'(bus.rev_count), 2);

    // glitch shorter than the filter window
    s0 = steps;
    e0 = errs;
    bus.pat_in = p[5];
    tick(3);
    bus.pat_in = p[2];
    tick(10);
    chk("glitch_steps", 32'(steps - s0), 0);
    chk("glitch_errs", 32'(errs - e0), 0);
    chk("glitch_phase", 32'(bus.phase), 2);

    bus.pat_in = inv;
    tick(8);
    chk("inv2_locked", 32'(bus.locked), 0);
    bus.pat_in = p[4];
    tick(6);
    chk("stall_lock", 32'(bus.locked), 1);
    tick(19);
    chk("stall_l19_locked", 32'(bus.locked), 1);
    chk("stall_l19_pulse", 32'(bus.err_pulse), 0);
    tick(1);
    chk("stall_code", 32'(bus.err_code), 3);
    chk("stall_pulse", 32'(bus.err_pulse), 1);
    chk("stall_locked", 32'(bus.locked), 0);
    chk("stall_pv", 32'(bus.phase_valid), 0);
    tick(1);
    chk("stall_pulse_w", 32'(bus.err_pulse), 0);
    chk("stall_errcnt", 32'(bus.err_count), 4);

    bus.pat_in = p[0];
    tick(6);
    chk("sat_lock", 32'(bus.locked), 1);
    for (int i = 0; i < 300; i++) begin
      bus.pat_in = (i % 2 == 0) ? p[2] : p[0];
      tick(6);
    end
    chk("sat_errcnt", 32'(bus.err_count), 255);
    chk("sat_code", 32'(bus.err_code), 1);
    chk("sat_locked", 32'(bus.locked), 1);

    bus.pat_in = p[2];
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("mrst_locked", 32'(bus.locked), 0);
    chk("mrst_pv", 32'(bus.phase_valid), 0);
    chk("mrst_phase", 32'(bus.phase), 0);
    chk("mrst_errcnt", 32'(bus.err_count), 0);
    chk("mrst_revcnt", 32'(bus.rev_count), 0);
    chk("mrst_code", 32'(bus.err_code), 0);
    chk("mrst_pulses",
        32'({bus.step_pulse, bus.err_pulse}), 0);
    bus.pat_in = 12'h000;
    rst_n = 1'b1;
    tick(12);
    chk("post_rst_locked", 32'(bus.locked), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
